// File: rtl/if_fetch_if.sv
// ---------------------------------------------------------------------------------------------
// if_fetch_if: byte-wide read bus between the instruction-fetch stage and the memory
// controller.
//
//   mem_req    fetch -> ctrl  byte read request, held until mem_ack
//   mem_addr   fetch -> ctrl  byte address, stable while mem_req=1
//   mem_ack    ctrl -> fetch  one byte is returned this cycle
//   mem_rdata  ctrl -> fetch  byte returned with mem_ack
//
// modport master: the fetch stage; modport slave: the memory controller.
// ---------------------------------------------------------------------------------------------
interface if_fetch_if #(
  parameter int unsigned ADDR_W = 32
) ();

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [7:0]        mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata
  );

endinterface

// File: rtl/if_fetch.sv
// ---------------------------------------------------------------------------------------------
// if_fetch: instruction-fetch stage directly downstream of the PC register.
//
// Returns the 32-bit instruction at pc. A direct-mapped I-cache (one word per line,
// 2**IDX_W lines) serves hits at one instruction per cycle. A miss assembles the word
// little-endian from four byte reads on the memory bus, fills the line and presents it.
//
// Ports
//   clk, rst    clock (posedge) and asynchronous active-high reset
//   pc          word-aligned fetch address from the PC register
//   jp          jump/branch taken: abort the fetch in flight, drop inst_valid
//   stall_in    downstream stall: hold inst / inst_pc / inst_valid
//   bus         byte-wide memory controller port (master side)
//   stall_req   fetch busy, PC must not advance
//   inst_valid  inst / inst_pc hold a valid instruction
//   inst        fetched instruction
//   inst_pc     PC of inst
// ---------------------------------------------------------------------------------------------
module if_fetch #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned IDX_W  = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  input  logic              jp,
  input  logic              stall_in,
  if_fetch_if.master        bus,
  output logic              stall_req,
  output logic              inst_valid,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] inst_pc
);

  localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;
  localparam int unsigned LINES = 1 << IDX_W;

  // StHold: a word completed while stall_in=1 and waits in word_q for stall_in=0.
  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StHold
  } state_t;

  state_t            state_q;
  logic [1:0]        k_q;
  logic [ADDR_W-1:0] pc_lat_q;
  logic [31:0]       word_q;
  logic [LINES-1:0]  valid_q;

  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [31:0]       data_mem [LINES];

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic [IDX_W-1:0]  fill_idx;
  logic [TAG_W-1:0]  fill_tag;
  logic              hit;
  logic              fill;
  logic [31:0]       fill_word;

  // Cache lookup on the live pc; fill uses the pc latched on miss.
  always_comb begin
    idx       = pc[IDX_W+1:2];
    tag       = pc[ADDR_W-1:IDX_W+2];
    fill_idx  = pc_lat_q[IDX_W+1:2];
    fill_tag  = pc_lat_q[ADDR_W-1:IDX_W+2];
    hit       = valid_q[idx] && (tag_mem[idx] == tag);
    // Last byte arrives straight from the bus; the lower three are already in word_q.
    fill_word = {bus.mem_rdata, word_q[23:0]};
    fill      = !rst && !jp && (state_q == StFetch) && bus.mem_ack && (k_q == 2'd3);
  end

  // Bus request and stall are combinational so a jump retracts the request and a miss
  // freezes the PC in the same cycle.
  always_comb begin
    bus.mem_req  = !rst && !jp && (state_q == StFetch);
    bus.mem_addr = pc_lat_q + ADDR_W'(k_q);
    stall_req    = !rst && ((state_q == StFetch) ||
                            ((state_q == StIdle) && !stall_in && !jp && !hit));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      k_q        <= 2'd0;
      pc_lat_q   <= '0;
      word_q     <= '0;
      valid_q    <= '0;
      inst_valid <= 1'b0;
      inst       <= '0;
      inst_pc    <= '0;
    end else if (jp) begin
      // Abort wins over stall_in and mem_ack; partial bytes are simply overwritten later.
      state_q    <= StIdle;
      k_q        <= 2'd0;
      inst_valid <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!stall_in) begin
            if (hit) begin
              inst       <= data_mem[idx];
              inst_pc    <= pc;
              inst_valid <= 1'b1;
            end else begin
              state_q    <= StFetch;
              k_q        <= 2'd0;
              pc_lat_q   <= pc;
              inst_valid <= 1'b0;
            end
          end
        end

        StFetch: begin
          if (bus.mem_ack) begin
            k_q                 <= k_q + 2'd1;
            word_q[8*k_q +: 8]  <= bus.mem_rdata;
          end
          if (fill) begin
            valid_q[fill_idx] <= 1'b1;
            if (stall_in) begin
              word_q  <= fill_word;
              state_q <= StHold;
            end else begin
              inst       <= fill_word;
              inst_pc    <= pc_lat_q;
              inst_valid <= 1'b1;
              state_q    <= StIdle;
            end
          end else if (!stall_in) begin
            inst_valid <= 1'b0;
          end
        end

        StHold: begin
          if (!stall_in) begin
            inst       <= word_q;
            inst_pc    <= pc_lat_q;
            inst_valid <= 1'b1;
            state_q    <= StIdle;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  // Tag/data arrays need no reset: valid_q gates every read.
  always_ff @(posedge clk) begin
    if (fill) begin
      tag_mem[fill_idx]  <= fill_tag;
      data_mem[fill_idx] <= fill_word;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// ---------------------------------------------------------------------------------------------
// tb_if_fetch: self-checking bench for if_fetch. The bench plays the memory controller
// (memory contents are a fixed function of the address) and keeps a transaction-level
// reference: the cache is a table of which fetch address owns each line, expected
// instructions come straight from the memory function.
// ---------------------------------------------------------------------------------------------
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        jp;
  logic        stall_in;
  logic        stall_req;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  if_fetch_if #(.ADDR_W(32)) bus ();

  if_fetch #(
    .ADDR_W(32),
    .IDX_W (7)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pc        (pc),
    .jp        (jp),
    .stall_in  (stall_in),
    .bus       (bus),
    .stall_req (stall_req),
    .inst_valid(inst_valid),
    .inst      (inst),
    .inst_pc   (inst_pc)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference state.
  bit          m_busy;   // miss in flight
  bit          m_pend;   // completed word waiting for stall_in=0
  int          m_nb;     // bytes received for the miss in flight
  logic [31:0] m_fpc;
  bit          m_iv;
  logic [31:0] m_inst;
  logic [31:0] m_ipc;
  bit          lv  [128];
  logic [31:0] lpc [128];

  function automatic logic [7:0] mb(input logic [31:0] a);
    if (a < 32'd4) return (a == 32'd0) ? 8'h13 : 8'h00;
    return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'hA5;
  endfunction

  function automatic logic [31:0] mw(input logic [31:0] a);
    return {mb(a + 32'd3), mb(a + 32'd2), mb(a + 32'd1), mb(a)};
  endfunction

  function automatic int lidx(input logic [31:0] a);
    return int'(a[8:2]);
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
    return lv[lidx(a)] && (lpc[lidx(a)] == a);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic present(input logic [31:0] a);
    m_inst = mw(a);
    m_ipc  = a;
    m_iv   = 1'b1;
  endtask

  task automatic model_reset();
    m_busy = 1'b0;
    m_pend = 1'b0;
    m_nb   = 0;
    m_fpc  = '0;
    m_iv   = 1'b0;
    m_inst = '0;
    m_ipc  = '0;
    for (int i = 0; i < 128; i++) begin
      lv[i]  = 1'b0;
      lpc[i] = '0;
    end
  endtask

  // One clock cycle, entered and left just after a falling edge.
  task automatic cycle(input logic [31:0] p, input bit j, input bit s, input bit a);
    bit ack;
    bit hit;
    bit exp_req;
    bit exp_stall;
    pc            = p;
    jp            = j;
    stall_in      = s;
    ack           = a && m_busy;
    bus.mem_ack   = ack;
    bus.mem_rdata = mb(m_fpc + m_nb);
    hit           = m_hit(p);
    exp_req       = m_busy && !j;
    exp_stall     = m_busy || (!m_pend && !s && !j && !hit);
    #2;
    check_eq("mem_req", bus.mem_req, exp_req);
    if (exp_req) check_eq("mem_addr", bus.mem_addr, m_fpc + m_nb);
    check_eq("stall_req", stall_req, exp_stall);
    @(posedge clk);
    if (j) begin
      m_iv   = 1'b0;
      m_busy = 1'b0;
      m_pend = 1'b0;
      m_nb   = 0;
    end else if (m_busy) begin
      if (ack) m_nb++;
      if (m_nb == 4) begin
        lv[lidx(m_fpc)]  = 1'b1;
        lpc[lidx(m_fpc)] = m_fpc;
        m_busy = 1'b0;
        m_nb   = 0;
        if (!s) present(m_fpc);
        else m_pend = 1'b1;
      end else if (!s) begin
        m_iv = 1'b0;
      end
    end else if (m_pend) begin
      if (!s) begin
        present(m_fpc);
        m_pend = 1'b0;
      end
    end else if (!s) begin
      if (hit) begin
        present(p);
      end else begin
        m_busy = 1'b1;
        m_fpc  = p;
        m_nb   = 0;
        m_iv   = 1'b0;
      end
    end
    #1;
    check_eq("inst_valid", inst_valid, m_iv);
    check_eq("inst", inst, m_inst);
    check_eq("inst_pc", inst_pc, m_ipc);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_iv"}, inst_valid, 1'b0);
    check_eq({tag, "_inst"}, inst, 32'd0);
    check_eq({tag, "_pc"}, inst_pc, 32'd0);
    check_eq({tag, "_req"}, bus.mem_req, 1'b0);
    check_eq({tag, "_stall"}, stall_req, 1'b0);
  endtask

  // Asynchronous reset asserted mid-cycle.
  task automatic async_reset(input string tag);
    rst = 1'b1;
    #1;
    model_reset();
    check_reset_outputs(tag);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic acks(input logic [31:0] p, input int n, input bit s);
    for (int i = 0; i < n; i++) cycle(p, 1'b0, s, 1'b1);
  endtask

  logic [31:0] pc_set [8];
  logic [31:0] last_pc;

  initial begin
    pc_set = '{32'h0, 32'h4, 32'h8, 32'h100, 32'h200, 32'h204, 32'h10, 32'h1000};
    rst = 1'b1;
    pc = '0;
    jp = 1'b0;
    stall_in = 1'b0;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    model_reset();
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Cold miss at 0x0, bytes 13,00,00,00.
    cycle(32'h0, 1'b0, 1'b0, 1'b0);
    acks(32'h0, 4, 1'b0);
    check_eq("t1_inst", inst, 32'h0000_0013);
    check_eq("t1_valid", inst_valid, 1'b1);

    // Refetch hits.
    cycle(32'h0, 1'b0, 1'b0, 1'b0);
    check_eq("t2_valid", inst_valid, 1'b1);

    // Jump after two bytes aborts; the line stays invalid.
    cycle(32'h100, 1'b0, 1'b0, 1'b0);
    acks(32'h100, 2, 1'b0);
    cycle(32'h100, 1'b1, 1'b0, 1'b1);
    check_eq("t3_valid", inst_valid, 1'b0);
    cycle(32'h100, 1'b0, 1'b0, 1'b0);
    check_eq("t3_remiss", stall_req, 1'b1);
    acks(32'h100, 4, 1'b0);

    // Completion under stall_in is buffered until stall_in drops.
    cycle(32'h4, 1'b0, 1'b0, 1'b0);
    acks(32'h4, 4, 1'b1);
    cycle(32'h4, 1'b0, 1'b1, 1'b0);
    cycle(32'h4, 1'b0, 1'b0, 1'b0);
    check_eq("t4_pc", inst_pc, 32'h4);
    check_eq("t4_valid", inst_valid, 1'b1);

    // 0x200 aliases 0x0 and evicts it.
    cycle(32'h0, 1'b0, 1'b0, 1'b0);
    cycle(32'h200, 1'b0, 1'b0, 1'b0);
    acks(32'h200, 4, 1'b0);
    cycle(32'h0, 1'b0, 1'b0, 1'b0);
    check_eq("t5_remiss", stall_req, 1'b1);
    acks(32'h0, 4, 1'b0);

    // Reset mid-fetch clears the cache.
    cycle(32'h8, 1'b0, 1'b0, 1'b0);
    acks(32'h8, 1, 1'b0);
    async_reset("t6");
    cycle(32'h0, 1'b0, 1'b0, 1'b0);
    check_eq("t6_miss", stall_req, 1'b1);
    acks(32'h0, 4, 1'b0);

    // Randomized traffic; the PC is frozen while the reference expects stall_req.
    last_pc = 32'h0;
    for (int n = 0; n < 1500; n++) begin
      logic [31:0] p;
      p = m_busy ? last_pc : pc_set[$urandom_range(7)];
      last_pc = p;
      cycle(p, ($urandom_range(15) == 0), ($urandom_range(3) == 0), $urandom_range(1) == 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
